program_builder: RTL and testbench

PROGRAM_BUILDER -- requirements
Module: program_builder

---
 rtl/program_builder.sv | 83 ++++++++
 tb/tb_program_builder.sv | 139 +++++++++++++
 2 files changed

// File: rtl/program_builder.sv
// program_builder: synchronises and debounces the mode/level/start keys and builds
// the packed phase-time word for the run countdown while the controller is in set.
module program_builder #(
    parameter int DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  state,
    input  logic        modeKey,
    input  logic        levelKey,
    input  logic        startKey,
    output logic [25:0] data,
    output logic [2:0]  mode,
    output logic [2:0]  level,
    output logic [6:0]  totalTime,
    output logic        startReq
);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);
    localparam logic [25:0] RST_DATA = 26'h1CA6D93;
    logic [2:0] raw, s1, s2, db, acc, press;
    logic [CW-1:0] cnt [3];
    logic in_set, wash, rinse, quick;
    logic [2:0] f7, f5, f4, f3, f1, f0;
    logic [3:0] f6, f2;
    logic [25:0] nxt_data;
    logic [6:0] nxt_total;

    assign raw = {startKey, levelKey, modeKey};
    assign in_set = state == 3'd2;

    // a level is accepted on the DEBOUNCE-th consecutive sample that differs from it
    always_comb begin
        for (int i = 0; i < 3; i++) acc[i] = (s2[i] != db[i]) && (cnt[i] == LAST);
        press = acc & s2;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            db <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            db <= db ^ acc;
            for (int i = 0; i < 3; i++) cnt[i] <= (s2[i] == db[i] || acc[i]) ? '0 : cnt[i] + 1'b1;
        end
    end

    always_comb begin
        wash      = mode == 3'd0 || mode == 3'd1;
        rinse     = mode == 3'd0 || mode == 3'd2;
        quick     = mode == 3'd4;
        f7        = (wash || quick) ? level : 3'd0;
        f6        = wash ? 4'd9 : quick ? 4'd4 : 4'd0;
        f5        = wash ? 3'd2 : quick ? 3'd1 : 3'd0;
        f4        = mode == 3'd0 ? 3'd3 : 3'd0;
        f3        = (rinse || quick) ? level : 3'd0;
        f2        = rinse ? 4'd6 : quick ? 4'd3 : 4'd0;
        f1        = rinse ? 3'd2 : quick ? 3'd1 : 3'd0;
        f0        = (rinse || mode == 3'd3) ? 3'd3 : quick ? 3'd2 : 3'd0;
        nxt_data  = {f7, f6, f5, f4, f3, f2, f1, f0};
        nxt_total = 7'(f7) + 7'(f6) + 7'(f5) + 7'(f4) + 7'(f3) + 7'(f2) + 7'(f1) + 7'(f0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode      <= 3'd0;
            level     <= 3'd3;
            startReq  <= 1'b0;
            data      <= RST_DATA;
            totalTime <= 7'd31;
        end else begin
            startReq  <= in_set && press[2];
            data      <= nxt_data;
            totalTime <= nxt_total;
            if (in_set && press[0]) mode <= (mode == 3'd4) ? 3'd0 : mode + 3'd1;
            if (in_set && press[1]) level <= (level == 3'd5) ? 3'd1 : level + 3'd1;
        end
    end
endmodule

// File: tb/tb_program_builder.sv
// tb_program_builder: directed-step bench for program_builder with hand-derived program words.
module tb_program_builder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  state = 3'd0;
    logic [2:0]  keys = 3'd0;
    logic [25:0] data;
    logic [2:0]  mode, level;
    logic [6:0]  totalTime;
    logic        startReq;
    int          checks = 0;
    int          fails = 0;
    int          sr_cnt = 0;
    int          sr_base;
    int          waited;
    logic [2:0]  lvl_at_change;

    program_builder #(.DEBOUNCE(4)) dut (
        .clk(clk), .rst_n(rst_n), .state(state),
        .modeKey(keys[0]), .levelKey(keys[1]), .startKey(keys[2]),
        .data(data), .mode(mode), .level(level), .totalTime(totalTime), .startReq(startReq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (startReq) sr_cnt <= sr_cnt + 1;

    function automatic logic [25:0] word(input logic [2:0] m, input logic [2:0] l);
        case (m)
            3'd0: return {l, 4'd9, 3'd2, 3'd3, l, 4'd6, 3'd2, 3'd3};
            3'd1: return {l, 4'd9, 3'd2, 3'd0, 3'd0, 4'd0, 3'd0, 3'd0};
            3'd2: return {3'd0, 4'd0, 3'd0, 3'd0, l, 4'd6, 3'd2, 3'd3};
            3'd3: return 26'd3;
            default: return {l, 4'd4, 3'd1, 3'd0, l, 4'd3, 3'd1, 3'd2};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int k, input int hold);
        keys[k] = 1'b1;
        cyc(hold);
        keys[k] = 1'b0;
        cyc(10);
    endtask

    initial begin
        cyc(3);
        rst_n = 1'b1;
        cyc(2);
        check("rst_data", 32'(data), 32'h1CA6D93);
        check("rst_mode", 32'(mode), 0);
        check("rst_level", 32'(level), 3);
        check("rst_total", 32'(totalTime), 31);
        check("rst_start", 32'(startReq), 0);

        state = 3'd2;
        press(1, 10);
        check("level_4", 32'(level), 4);
        press(1, 10);
        check("level_5", 32'(level), 5);
        press(1, 10);
        check("level_wrap", 32'(level), 1);
        check("data_l1", 32'(data), 32'(word(3'd0, 3'd1)));
        check("total_l1", 32'(totalTime), 27);

        for (int i = 1; i <= 5; i++) begin
            press(0, 10);
            check("mode_step", 32'(mode), 32'(i % 5));
            if (i == 3) begin
                check("data_m3", 32'(data), 32'h3);
                check("total_m3", 32'(totalTime), 3);
            end
            if (i == 4) check("data_m4", 32'(data), 32'(word(3'd4, 3'd1)));
        end

        state = 3'd3;
        press(0, 10);
        press(1, 10);
        press(2, 10);
        check("run_mode", 32'(mode), 0);
        check("run_level", 32'(level), 1);
        check("run_data", 32'(data), 32'(word(3'd0, 3'd1)));
        check("run_start", 32'(sr_cnt), 0);

        state = 3'd2;
        press(0, 3);
        check("glitch", 32'(mode), 0);
        press(0, 20);
        check("held_once", 32'(mode), 1);

        keys[0] = 1'b1;
        keys[1] = 1'b1;
        waited = 0;
        while (mode == 3'd1 && waited < 20) begin
            cyc(1);
            waited++;
        end
        lvl_at_change = level;
        keys[0] = 1'b0;
        keys[1] = 1'b0;
        cyc(10);
        check("both_mode", 32'(mode), 2);
        check("both_same_cycle", 32'(lvl_at_change), 2);
        check("both_data", 32'(data), 32'(word(3'd2, 3'd2)));

        sr_base = sr_cnt;
        press(2, 10);
        check("start_pulse", 32'(sr_cnt - sr_base), 1);
        check("start_keep_mode", 32'(mode), 2);

        keys[0] = 1'b1;
        cyc(4);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        check("midrst_mode", 32'(mode), 0);
        cyc(12);
        check("midrst_event", 32'(mode), 1);
        keys[0] = 1'b0;
        cyc(10);
        check("midrst_once", 32'(mode), 1);
        check("midrst_level", 32'(level), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
